// File: rtl/hatch_loader_if.sv
// rtl/hatch_loader_if.sv - download byte stream, CPU fetch port and loader status bundle
interface hatch_loader_if #(
  parameter int ADDR_W = 10
);
  logic [7:0]      rx_data;
  logic            rx_valid;
  logic [31:0]     hatch_address;
  logic [47:0]     hatch_instruction;
  logic            cpu_rst_b;
  logic            loading;
  logic            load_err;
  logic [ADDR_W:0] words_loaded;

  // Byte source and CPU side
  modport master (
    output rx_data, rx_valid, hatch_address,
    input  hatch_instruction, cpu_rst_b, loading, load_err, words_loaded
  );

  // Loader side
  modport slave (
    input  rx_data, rx_valid, hatch_address,
    output hatch_instruction, cpu_rst_b, loading, load_err, words_loaded
  );
endinterface

// File: rtl/hatch_loader.sv
// rtl/hatch_loader.sv - byte-stream program loader feeding a 48-bit instruction store
module hatch_loader #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         ADDR_W    = 10,
  parameter int         TIMEOUT   = 1000000
) (
  input  logic          clk,
  input  logic          rst,
  hatch_loader_if.slave bus
);
  localparam int              DEPTH   = 1 << ADDR_W;
  localparam int              TW      = $clog2(TIMEOUT + 1);
  localparam logic [16:0]     MAX_LEN = 17'(DEPTH);
  localparam logic [TW-1:0]   T_LAST  = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0]   T_ONE   = TW'(1);
  localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W + 1)'(1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LEN_LO = 3'd1;
  localparam logic [2:0] ST_LEN_HI = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_RUN    = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [15:0]     len_q, len_d;
  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [2:0]      byte_cnt_q, byte_cnt_d;
  logic [39:0]     shift_q, shift_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            err_q, err_d;
  logic [ADDR_W:0] words_q, words_d;
  logic            cpu_rst_b_q;
  logic            we;
  logic [47:0]     wdata;
  logic            in_load;

  logic [47:0] store_q [0:DEPTH-1];

  // Upper fetch-address bits are ignored; the store wraps on its own depth
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.hatch_address[31:ADDR_W];

  assign in_load = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) || (state_q == ST_DATA);

  // Next-state: sync hunt, length capture, word assembly and inter-byte timeout
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    wr_ptr_d   = wr_ptr_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    timer_d    = timer_q;
    err_d      = err_q;
    words_d    = words_q;
    we         = 1'b0;
    wdata      = {shift_q, bus.rx_data};

    if (in_load) begin
      if (bus.rx_valid) begin
        timer_d = '0;
      end else if (timer_q == T_LAST) begin
        state_d = ST_IDLE;
        err_d   = 1'b1;
        timer_d = '0;
      end else begin
        timer_d = timer_q + T_ONE;
      end
    end

    case (state_q)
      ST_IDLE, ST_RUN: begin
        if (bus.rx_valid && bus.rx_data == SYNC_BYTE) begin
          state_d = ST_LEN_LO;
          timer_d = '0;
        end
      end
      ST_LEN_LO: begin
        if (bus.rx_valid) begin
          len_d[7:0] = bus.rx_data;
          state_d    = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (bus.rx_valid) begin
          len_d[15:8] = bus.rx_data;
          if ({bus.rx_data, len_q[7:0]} == 16'd0 ||
              {1'b0, bus.rx_data, len_q[7:0]} > MAX_LEN) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end else begin
            state_d    = ST_DATA;
            wr_ptr_d   = '0;
            byte_cnt_d = '0;
          end
        end
      end
      ST_DATA: begin
        if (bus.rx_valid) begin
          if (byte_cnt_q == 3'd5) begin
            we         = 1'b1;
            byte_cnt_d = '0;
            wr_ptr_d   = wr_ptr_q + PTR_ONE;
            // Last word of the image: hand the store to the CPU
            if (17'(wr_ptr_q) + 17'd1 == {1'b0, len_q}) begin
              state_d = ST_RUN;
              words_d = wr_ptr_q + PTR_ONE;
              err_d   = 1'b0;
            end
          end else begin
            shift_d    = {shift_q[31:0], bus.rx_data};
            byte_cnt_d = byte_cnt_q + 3'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers; cpu_rst_b trails the state by one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      wr_ptr_q    <= '0;
      byte_cnt_q  <= '0;
      shift_q     <= '0;
      timer_q     <= '0;
      err_q       <= 1'b0;
      words_q     <= '0;
      cpu_rst_b_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      wr_ptr_q    <= wr_ptr_d;
      byte_cnt_q  <= byte_cnt_d;
      shift_q     <= shift_d;
      timer_q     <= timer_d;
      err_q       <= err_d;
      words_q     <= words_d;
      cpu_rst_b_q <= (state_q == ST_RUN);
    end
  end

  // Instruction store write; contents survive reset, but reset blocks a pending write
  always_ff @(posedge clk) begin
    if (we && !rst) begin
      store_q[wr_ptr_q[ADDR_W-1:0]] <= wdata;
    end
  end

  assign bus.hatch_instruction = (state_q == ST_RUN) ?
                                 store_q[bus.hatch_address[ADDR_W-1:0]] : 48'h0;
  assign bus.cpu_rst_b    = cpu_rst_b_q;
  assign bus.loading      = in_load;
  assign bus.load_err     = err_q;
  assign bus.words_loaded = words_q;
endmodule

// File: tb/tb_hatch_loader.sv
// tb/tb_hatch_loader.sv - self-checking bench for hatch_loader
module tb_hatch_loader;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hatch_loader_if #(.ADDR_W(AW)) bus ();

  hatch_loader #(.SYNC_BYTE(8'hA5), .ADDR_W(AW), .TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [31:0] addr;
    logic [47:0] data;
  } rd_t;

  rd_t         sb[$];
  logic [47:0] model [0:DEPTH-1];
  int          total = 0;
  int          bad   = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    step();
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
  endtask

  task automatic start(input logic [15:0] n);
    send(8'hA5);
    send(n[7:0]);
    send(n[15:8]);
  endtask

  task automatic expect_read(input logic [31:0] addr, input logic [47:0] data);
    rd_t r;
    r.addr = addr;
    r.data = data;
    sb.push_back(r);
  endtask

  task automatic send_word(input int addr, input logic [47:0] w);
    for (int i = 0; i < 6; i++) send(w[47-8*i -: 8]);
    model[addr] = w;
    expect_read(32'(addr), w);
  endtask

  task automatic drain_reads();
    rd_t r;
    while (sb.size() > 0) begin
      r = sb.pop_front();
      bus.hatch_address = r.addr;
      #1;
      total++;
      if (bus.hatch_instruction !== r.data) begin
        bad++;
        $display("FAIL read addr=%h got=%h exp=%h", r.addr, bus.hatch_instruction, r.data);
      end
    end
    bus.hatch_address = 32'h0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    total++; if (bus.cpu_rst_b !== 1'b0) begin bad++; $display("FAIL rst_cpu_rst_b got=%b exp=0", bus.cpu_rst_b); end
    total++; if (bus.loading !== 1'b0) begin bad++; $display("FAIL rst_loading got=%b exp=0", bus.loading); end
    total++; if (bus.load_err !== 1'b0) begin bad++; $display("FAIL rst_load_err got=%b exp=0", bus.load_err); end
    total++; if (bus.words_loaded !== 11'd0) begin bad++; $display("FAIL rst_words got=%0d exp=0", bus.words_loaded); end
    total++; if (bus.hatch_instruction !== 48'h0) begin bad++; $display("FAIL rst_instr got=%h exp=0", bus.hatch_instruction); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    send(8'h00);
    send(8'h5A);
    total++; if (bus.loading !== 1'b0) begin bad++; $display("FAIL idle_ignore got=%b exp=0", bus.loading); end
    start(16'd2);
    total++; if (bus.loading !== 1'b1) begin bad++; $display("FAIL basic_loading got=%b exp=1", bus.loading); end
    send_word(0, 48'h112233445566);
    send_word(1, 48'hAABBCCDDEEFF);
    total++; if (bus.loading !== 1'b0) begin bad++; $display("FAIL basic_done got=%b exp=0", bus.loading); end
    total++; if (bus.cpu_rst_b !== 1'b0) begin bad++; $display("FAIL basic_rst_lag got=%b exp=0", bus.cpu_rst_b); end
    total++; if (bus.words_loaded !== 11'd2) begin bad++; $display("FAIL basic_words got=%0d exp=2", bus.words_loaded); end
    step();
    total++; if (bus.cpu_rst_b !== 1'b1) begin bad++; $display("FAIL basic_cpu_run got=%b exp=1", bus.cpu_rst_b); end
    drain_reads();
    send(8'h11);
    total++; if (bus.cpu_rst_b !== 1'b1 || bus.loading !== 1'b0) begin bad++; $display("FAIL run_ignore got=%b%b exp=10", bus.cpu_rst_b, bus.loading); end
  endtask

  task automatic test_redownload();
    send(8'hA5);
    total++; if (bus.loading !== 1'b1) begin bad++; $display("FAIL redl_loading got=%b exp=1", bus.loading); end
    total++; if (bus.hatch_instruction !== 48'h0) begin bad++; $display("FAIL redl_instr got=%h exp=0", bus.hatch_instruction); end
    send(8'h01);
    total++; if (bus.cpu_rst_b !== 1'b0) begin bad++; $display("FAIL redl_cpu_rst got=%b exp=0", bus.cpu_rst_b); end
    send(8'h00);
    send_word(0, 48'h010203040506);
    expect_read(32'd1, model[1]);
    total++; if (bus.words_loaded !== 11'd1) begin bad++; $display("FAIL redl_words got=%0d exp=1", bus.words_loaded); end
    step();
    drain_reads();
  endtask

  task automatic test_bad_length();
    logic [15:0] lens [2];
    lens[0] = 16'h0000;
    lens[1] = 16'h0401;
    for (int k = 0; k < 2; k++) begin
      start(lens[k]);
      step();
      total++; if (bus.loading !== 1'b0) begin bad++; $display("FAIL badlen_loading len=%h got=%b exp=0", lens[k], bus.loading); end
      total++; if (bus.load_err !== 1'b1) begin bad++; $display("FAIL badlen_err len=%h got=%b exp=1", lens[k], bus.load_err); end
      total++; if (bus.cpu_rst_b !== 1'b0) begin bad++; $display("FAIL badlen_cpu len=%h got=%b exp=0", lens[k], bus.cpu_rst_b); end
      total++; if (bus.words_loaded !== 11'd1) begin bad++; $display("FAIL badlen_words len=%h got=%0d exp=1", lens[k], bus.words_loaded); end
    end
  endtask

  task automatic test_timeout();
    start(16'd1);
    send(8'h11);
    send(8'h22);
    repeat (15) step();
    total++; if (bus.loading !== 1'b1) begin bad++; $display("FAIL to_early got=%b exp=1", bus.loading); end
    step();
    total++; if (bus.loading !== 1'b0) begin bad++; $display("FAIL to_abort got=%b exp=0", bus.loading); end
    total++; if (bus.load_err !== 1'b1) begin bad++; $display("FAIL to_err got=%b exp=1", bus.load_err); end
    total++; if (bus.words_loaded !== 11'd1) begin bad++; $display("FAIL to_words got=%0d exp=1", bus.words_loaded); end
    start(16'd1);
    send_word(0, 48'h0A0B0C0D0E0F);
    expect_read(32'd1, model[1]);
    total++; if (bus.load_err !== 1'b0) begin bad++; $display("FAIL to_clear got=%b exp=0", bus.load_err); end
    step();
    drain_reads();
  endtask

  task automatic test_full_depth();
    logic [47:0] w;
    start(16'h0400);
    for (int i = 0; i < DEPTH; i++) begin
      w = {16'(i) ^ 16'h5A5A, 16'(i * 7 + 3), ~16'(i)};
      send_word(i, w);
      if (i == DEPTH - 2) begin
        total++; if (bus.loading !== 1'b1) begin bad++; $display("FAIL full_early got=%b exp=1", bus.loading); end
      end
    end
    total++; if (bus.loading !== 1'b0) begin bad++; $display("FAIL full_done got=%b exp=0", bus.loading); end
    total++; if (bus.words_loaded !== 11'd1024) begin bad++; $display("FAIL full_words got=%0d exp=1024", bus.words_loaded); end
    expect_read(32'hFFFF_FC00, model[0]);
    step();
    drain_reads();
  endtask

  task automatic test_reset_mid();
    start(16'd2);
    send(8'h11);
    send(8'h22);
    send(8'h33);
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (bus.cpu_rst_b !== 1'b0) begin bad++; $display("FAIL mid_cpu got=%b exp=0", bus.cpu_rst_b); end
    total++; if (bus.loading !== 1'b0) begin bad++; $display("FAIL mid_loading got=%b exp=0", bus.loading); end
    total++; if (bus.load_err !== 1'b0) begin bad++; $display("FAIL mid_err got=%b exp=0", bus.load_err); end
    total++; if (bus.words_loaded !== 11'd0) begin bad++; $display("FAIL mid_words got=%0d exp=0", bus.words_loaded); end
    total++; if (bus.hatch_instruction !== 48'h0) begin bad++; $display("FAIL mid_instr got=%h exp=0", bus.hatch_instruction); end
    send(8'h01);
    send(8'h00);
    send(8'h02);
    total++; if (bus.loading !== 1'b0) begin bad++; $display("FAIL mid_ignore got=%b exp=0", bus.loading); end
    start(16'd1);
    send_word(0, 48'h777777777777);
    expect_read(32'd1, model[1]);
    total++; if (bus.words_loaded !== 11'd1) begin bad++; $display("FAIL mid_reload got=%0d exp=1", bus.words_loaded); end
    step();
    drain_reads();
  endtask

  initial begin
    bus.rx_data       = 8'h00;
    bus.rx_valid      = 1'b0;
    bus.hatch_address = 32'h0;
    rst               = 1'b1;
    test_reset();
    test_basic();
    test_redownload();
    test_bad_length();
    test_timeout();
    test_full_depth();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
